miniled_zone_buffer: RTL and testbench



---
 rtl/miniled_zone_buffer.sv | 136 +++++++++++++
 tb/tb_miniled_zone_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/miniled_zone_buffer.sv
// Double-buffered zone brightness store feeding the MiniLED driver.
// Zone writes land in a back bank. At a driver-safe swap point the back bank is
// copied into the front bank. The front bank is presented through a registered
// mode mux as a flat vector.
// Optional feature: define ZONE_GAIN_EN to scale every output zone by (I_gain+1)/256.
module miniled_zone_buffer #(
    parameter int unsigned NUM_ZONES = 360,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IDX_W     = 9
) (
    input  logic                        I_clk,
    input  logic                        I_rst_n,
    input  logic                        I_wr_en,
    input  logic [IDX_W-1:0]            I_wr_idx,
    input  logic [DATA_W-1:0]           I_wr_data,
    input  logic                        I_frame_done,
    input  logic                        I_swap_ok,
    input  logic [1:0]                  I_mode,
    input  logic [7:0]                  I_gain,
    output logic [NUM_ZONES*DATA_W-1:0] O_led_light,
    output logic                        O_frame_pending,
    output logic                        O_swap_pulse,
    output logic                        O_wr_err,
    output logic [15:0]                 O_frame_cnt
);

    localparam int unsigned LED_W  = NUM_ZONES * DATA_W;
    localparam int unsigned PROD_W = DATA_W + 8;
    localparam logic [DATA_W-1:0] ZONE_MAX = '1;

    logic [DATA_W-1:0] back_q  [NUM_ZONES];
    logic [DATA_W-1:0] front_q [NUM_ZONES];

    logic              pending_q, pending_d;
    logic              phase_q, phase_d;
    logic              swap_pulse_q;
    logic              wr_err_q, wr_err_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [DATA_W-1:0] zone_v;

    logic              idx_ok_c;
    logic              wr_ok_c;
    logic              swap_c;

    assign idx_ok_c = 32'(I_wr_idx) < NUM_ZONES;
    assign wr_ok_c  = I_wr_en && idx_ok_c;
    assign swap_c   = pending_q && I_swap_ok;

`ifdef ZONE_GAIN_EN
    // Scale one zone value by (gain+1)/256 at full product width.
    function automatic logic [DATA_W-1:0] apply_gain(input logic [DATA_W-1:0] v,
                                                     input logic [7:0]        g);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(v) * PROD_W'({1'b0, g} + 9'd1);
        return DATA_W'(prod >> 8);
    endfunction
`else
    logic unused_gain;
    assign unused_gain = ^I_gain;
`endif

    // Pending/phase/counter/pulse next state; a new frame_done beats the clearing swap.
    always_comb begin
        pending_d   = pending_q;
        phase_d     = phase_q ^ swap_c;
        frame_cnt_d = frame_cnt_q + 16'(swap_c);
        wr_err_d    = I_wr_en && !idx_ok_c;
        if (swap_c) begin
            pending_d = 1'b0;
        end
        if (I_frame_done) begin
            pending_d = 1'b1;
        end
    end

    // Output mode mux over the current front bank and phase.
    always_comb begin
        led_d  = '0;
        zone_v = '0;
        for (int i = 0; i < int'(NUM_ZONES); i++) begin
            case (I_mode)
                2'b00:   zone_v = front_q[i];
                2'b01:   zone_v = ZONE_MAX;
                2'b10:   zone_v = (1'(i) ^ phase_q) ? ZONE_MAX : '0;
                default: zone_v = '0;
            endcase
`ifdef ZONE_GAIN_EN
            led_d[i*DATA_W +: DATA_W] = apply_gain(zone_v, I_gain);
`else
            led_d[i*DATA_W +: DATA_W] = zone_v;
`endif
        end
    end

    // Back-bank writes and whole-bank commit into the front bank.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            back_q  <= '{default: '0};
            front_q <= '{default: '0};
        end else begin
            if (swap_c) begin
                front_q <= back_q;
            end
            if (wr_ok_c) begin
                back_q[I_wr_idx] <= I_wr_data;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pending_q    <= 1'b0;
            phase_q      <= 1'b0;
            swap_pulse_q <= 1'b0;
            wr_err_q     <= 1'b0;
            frame_cnt_q  <= '0;
            led_q        <= '0;
        end else begin
            pending_q    <= pending_d;
            phase_q      <= phase_d;
            swap_pulse_q <= swap_c;
            wr_err_q     <= wr_err_d;
            frame_cnt_q  <= frame_cnt_d;
            led_q        <= led_d;
        end
    end

    assign O_led_light     = led_q;
    assign O_frame_pending = pending_q;
    assign O_swap_pulse    = swap_pulse_q;
    assign O_wr_err        = wr_err_q;
    assign O_frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_miniled_zone_buffer.sv
// Self-checking bench for miniled_zone_buffer: directed scenarios plus random
// traffic, checked every cycle against a frame-level reference model.
module tb_miniled_zone_buffer;

    localparam int NZ = 360;
    localparam int DW = 8;
    localparam int IW = 9;

    logic              I_clk;
    logic              I_rst_n;
    logic              I_wr_en;
    logic [IW-1:0]     I_wr_idx;
    logic [DW-1:0]     I_wr_data;
    logic              I_frame_done;
    logic              I_swap_ok;
    logic [1:0]        I_mode;
    logic [7:0]        I_gain;
    logic [NZ*DW-1:0]  O_led_light;
    logic              O_frame_pending;
    logic              O_swap_pulse;
    logic              O_wr_err;
    logic [15:0]       O_frame_cnt;

    miniled_zone_buffer #(.NUM_ZONES(NZ), .DATA_W(DW), .IDX_W(IW)) dut (
        .I_clk          (I_clk),
        .I_rst_n        (I_rst_n),
        .I_wr_en        (I_wr_en),
        .I_wr_idx       (I_wr_idx),
        .I_wr_data      (I_wr_data),
        .I_frame_done   (I_frame_done),
        .I_swap_ok      (I_swap_ok),
        .I_mode         (I_mode),
        .I_gain         (I_gain),
        .O_led_light    (O_led_light),
        .O_frame_pending(O_frame_pending),
        .O_swap_pulse   (O_swap_pulse),
        .O_wr_err       (O_wr_err),
        .O_frame_cnt    (O_frame_cnt)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    // Reference model state: frame banks and flags as plain integers.
    int m_back  [NZ];
    int m_front [NZ];
    int m_led   [NZ];
    int m_pending, m_phase, m_cnt, m_swp, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dz(input int z);
        return O_led_light[z*DW +: DW];
    endfunction

    function automatic int bad_zones_vs(input int val);
        int bad = 0;
        for (int z = 0; z < NZ; z++) if (int'(dz(z)) != val) bad++;
        return bad;
    endfunction

    task automatic model_clear();
        for (int z = 0; z < NZ; z++) begin
            m_back[z] = 0; m_front[z] = 0; m_led[z] = 0;
        end
        m_pending = 0; m_phase = 0; m_cnt = 0; m_swp = 0; m_err = 0;
    endtask

    // One clock edge of the behaviour, using pre-edge state throughout.
    task automatic model_step();
        int v;
        int swap;
        swap = (m_pending != 0 && I_swap_ok) ? 1 : 0;
        for (int z = 0; z < NZ; z++) begin
            case (I_mode)
                2'd0: v = m_front[z];
                2'd1: v = 255;
                2'd2: v = (((z % 2) ^ m_phase) == 1) ? 255 : 0;
                default: v = 0;
            endcase
`ifdef ZONE_GAIN_EN
            v = (v * (int'(I_gain) + 1)) / 256;
`endif
            m_led[z] = v;
        end
        if (swap == 1) begin
            for (int z = 0; z < NZ; z++) m_front[z] = m_back[z];
            m_phase = 1 - m_phase;
            m_cnt   = (m_cnt + 1) % 65536;
        end
        if (I_wr_en && int'(I_wr_idx) < NZ) m_back[int'(I_wr_idx)] = int'(I_wr_data);
        m_err = (I_wr_en && int'(I_wr_idx) >= NZ) ? 1 : 0;
        if (I_frame_done) m_pending = 1;
        else if (swap == 1) m_pending = 0;
        m_swp = swap;
    endtask

    task automatic check_all();
        int bad = 0;
        for (int z = 0; z < NZ; z++) if (dz(z) !== 8'(m_led[z])) bad++;
        chk("led_zones_bad", 32'(bad), 32'd0);
        chk("pending", 32'(O_frame_pending), 32'(m_pending));
        chk("swap_pulse", 32'(O_swap_pulse), 32'(m_swp));
        chk("wr_err", 32'(O_wr_err), 32'(m_err));
        chk("frame_cnt", 32'(O_frame_cnt), 32'(m_cnt));
    endtask

    task automatic idle();
        I_wr_en = 1'b0; I_wr_idx = '0; I_wr_data = '0;
        I_frame_done = 1'b0; I_swap_ok = 1'b0;
    endtask

    task automatic cycle();
        @(posedge I_clk);
        model_step();
        @(negedge I_clk);
        if (O_swap_pulse) pulses++;
        check_all();
    endtask

    task automatic do_reset();
        I_rst_n = 1'b0;
        idle();
        repeat (2) @(negedge I_clk);
        model_clear();
        check_all();
        I_rst_n = 1'b1;
    endtask

    task automatic write_zone(input int idx, input int data);
        I_wr_en = 1'b1; I_wr_idx = IW'(idx); I_wr_data = DW'(data);
        cycle();
        I_wr_en = 1'b0;
    endtask

    initial begin
        I_rst_n = 1'b0;
        I_mode  = 2'd0;
        I_gain  = 8'd255;
        idle();
        model_clear();

        // Reset and idle.
        do_reset();
        repeat (100) cycle();
        chk("idle_led_bad", 32'(bad_zones_vs(0)), 32'd0);
        chk("idle_cnt", 32'(O_frame_cnt), 32'd0);
        chk("idle_pending", 32'(O_frame_pending), 32'd0);

        // Frame commit.
        for (int i = 0; i < NZ; i++) write_zone(i, i % 256);
        I_frame_done = 1'b1; cycle(); I_frame_done = 1'b0;
        chk("commit_pending", 32'(O_frame_pending), 32'd1);
        repeat (10) cycle();
        pulses = 0;
        I_swap_ok = 1'b1; cycle(); I_swap_ok = 1'b0;
        cycle();
        chk("commit_z359", 32'(dz(359)), 32'h67);
        repeat (5) cycle();
        chk("commit_pulses", 32'(pulses), 32'd1);
        chk("commit_cnt", 32'(O_frame_cnt), 32'd1);

        // Swap gating: no frame_done means no swap.
        do_reset();
        write_zone(5, 8'hAA);
        I_swap_ok = 1'b1;
        repeat (5) cycle();
        chk("gate_z5_hold", 32'(dz(5)), 32'd0);
        I_frame_done = 1'b1; cycle(); I_frame_done = 1'b0;
        cycle();
        chk("gate_z5_pre", 32'(dz(5)), 32'd0);
        cycle();
        chk("gate_z5", 32'(dz(5)), 32'hAA);
        I_swap_ok = 1'b0;

        // Write colliding with a swap lands in back only.
        I_frame_done = 1'b1; cycle(); I_frame_done = 1'b0;
        I_swap_ok = 1'b1; I_wr_en = 1'b1; I_wr_idx = '0; I_wr_data = 8'h11;
        cycle();
        idle(); cycle(); cycle();
        chk("coll_z0_old", 32'(dz(0)), 32'd0);
        I_frame_done = 1'b1; cycle(); I_frame_done = 1'b0;
        I_swap_ok = 1'b1; cycle(); I_swap_ok = 1'b0; cycle();
        chk("coll_z0_new", 32'(dz(0)), 32'h11);

        // Out-of-range write.
        write_zone(360, 8'h55);
        chk("wr_err_pulse", 32'(O_wr_err), 32'd1);
        cycle();
        chk("wr_err_clear", 32'(O_wr_err), 32'd0);
        write_zone(511, 8'h66);
        chk("wr_err_511", 32'(O_wr_err), 32'd1);

        // Modes, starting from phase 0.
        do_reset();
        I_mode = 2'd1; cycle();
        chk("m01_bad", 32'(bad_zones_vs(255)), 32'd0);
        I_mode = 2'd2; cycle();
        chk("m10_z0", 32'(dz(0)), 32'h00);
        chk("m10_z1", 32'(dz(1)), 32'hFF);
        I_frame_done = 1'b1; cycle(); I_frame_done = 1'b0;
        I_swap_ok = 1'b1; cycle(); I_swap_ok = 1'b0; cycle();
        chk("m10_swap_z0", 32'(dz(0)), 32'hFF);
        chk("m10_swap_z1", 32'(dz(1)), 32'h00);
        I_mode = 2'd3; cycle();
        chk("m11_bad", 32'(bad_zones_vs(0)), 32'd0);
`ifdef ZONE_GAIN_EN
        I_mode = 2'd1; I_gain = 8'd127; cycle();
        chk("gain127_bad", 32'(bad_zones_vs(8'h7F)), 32'd0);
        I_gain = 8'd255; cycle();
        chk("gain255_bad", 32'(bad_zones_vs(8'hFF)), 32'd0);
        I_gain = 8'd0; cycle();
        chk("gain0_bad", 32'(bad_zones_vs(0)), 32'd0);
        I_gain = 8'd255;
`endif
        I_mode = 2'd0;

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            I_wr_en      = ($urandom_range(0, 1) == 1);
            I_wr_idx     = IW'($urandom_range(0, 511));
            I_wr_data    = DW'($urandom);
            I_frame_done = ($urandom_range(0, 19) == 0);
            I_swap_ok    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) I_mode = 2'($urandom);
            if ($urandom_range(0, 49) == 0) I_gain = 8'($urandom);
            cycle();
        end
        idle();
        I_mode = 2'd0;

        // Reset mid-frame discards partial data.
        for (int i = 0; i < 20; i++) write_zone(i, 8'hC3);
        do_reset();
        I_frame_done = 1'b1; cycle(); I_frame_done = 1'b0;
        I_swap_ok = 1'b1; cycle(); I_swap_ok = 1'b0; cycle();
        chk("midrst_z3", 32'(dz(3)), 32'd0);
        chk("midrst_cnt", 32'(O_frame_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
